// File: rtl/vlog_street_sensor.sv
// Vehicle-presence front end for one street approach: synchronises and debounces the loop
// sensor, keeps the red-phase queue count and raises the controller's waiting request.
module vlog_street_sensor #(
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned DEPART_CYCLES = 2,
  parameter int unsigned STUCK_LIMIT   = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       car_raw_i,
  input  logic       green_i,
  output logic       waiting_o,
  output logic       arrival_o,
  output logic [3:0] car_count_o,
  output logic       sensor_fault_o
);

  localparam logic [3:0] DebLim   = 4'(DEBOUNCE);
  localparam logic [3:0] DepLim   = 4'(DEPART_CYCLES);
  localparam logic [7:0] StuckLim = 8'(STUCK_LIMIT);

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StArm  = 4'b0010,
    StPres = 4'b0100,
    StRel  = 4'b1000
  } deb_state_e;

  deb_state_e state_q, state_d;

  logic       sync1_q, s_q;
  logic [3:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
  logic [3:0] dep_timer_q, dep_timer_d, dep_timer_inc;
  logic [7:0] stuck_q, stuck_d;
  logic [3:0] car_count_q, car_count_d;
  logic       fault_q, fault_d;
  logic       waiting_q, waiting_d;
  logic       arrival_q, arrival_d;
  logic       accept, depart, in_pres;

  // Two-flop synchroniser; s_q is the only consumer of the raw sensor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= car_raw_i;
      s_q     <= sync1_q;
    end
  end

  // Debounce FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      deb_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign deb_cnt_inc = deb_cnt_q + 4'd1;

  // Debounce FSM: next state. deb_cnt counts consecutive qualifying samples.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (s_q) begin
          state_d   = StArm;
          deb_cnt_d = 4'd1;
        end else begin
          deb_cnt_d = 4'd0;
        end
      end
      StArm: begin
        if (!s_q) begin
          state_d   = StIdle;
          deb_cnt_d = 4'd0;
        end else if (deb_cnt_inc == DebLim) begin
          state_d   = StPres;
          deb_cnt_d = 4'd0;
        end else begin
          deb_cnt_d = deb_cnt_inc;
        end
      end
      StPres: begin
        if (!s_q) begin
          state_d   = StRel;
          deb_cnt_d = 4'd1;
        end else begin
          deb_cnt_d = 4'd0;
        end
      end
      StRel: begin
        if (s_q) begin
          state_d   = StPres;
          deb_cnt_d = 4'd0;
        end else if (deb_cnt_inc == DebLim) begin
          state_d   = StIdle;
          deb_cnt_d = 4'd0;
        end else begin
          deb_cnt_d = deb_cnt_inc;
        end
      end
      default: begin
        state_d   = StIdle;
        deb_cnt_d = 4'd0;
      end
    endcase
  end

  // Debounce FSM: outputs. A vehicle is accepted only on the ARM -> PRES edge.
  always_comb begin
    accept    = (state_q == StArm) && s_q && (deb_cnt_inc == DebLim);
    arrival_d = accept;
    in_pres   = (state_q == StPres);
  end

  assign dep_timer_inc = dep_timer_q + 4'd1;

  // Departure timer only runs while green with a non-empty queue; anything else discards it.
  always_comb begin
    dep_timer_d = 4'd0;
    depart      = 1'b0;
    if (green_i && (car_count_q != 4'd0)) begin
      if (dep_timer_inc == DepLim) begin
        depart = 1'b1;
      end else begin
        dep_timer_d = dep_timer_inc;
      end
    end
  end

  always_comb begin
    car_count_d = car_count_q;
    if (accept && !depart) begin
      if (car_count_q != 4'd15) begin
        car_count_d = car_count_q + 4'd1;
      end
    end else if (depart && !accept) begin
      if (car_count_q != 4'd0) begin
        car_count_d = car_count_q - 4'd1;
      end
    end
  end

  // Stuck monitor: consecutive PRES cycles; the fault is sticky until reset.
  always_comb begin
    stuck_d = 8'd0;
    if (in_pres) begin
      stuck_d = (stuck_q == 8'hFF) ? stuck_q : stuck_q + 8'd1;
    end
    fault_d   = fault_q | (in_pres && (stuck_d == StuckLim));
    waiting_d = (car_count_d != 4'd0) | fault_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dep_timer_q <= 4'd0;
      car_count_q <= 4'd0;
      stuck_q     <= 8'd0;
      fault_q     <= 1'b0;
      waiting_q   <= 1'b0;
      arrival_q   <= 1'b0;
    end else begin
      dep_timer_q <= dep_timer_d;
      car_count_q <= car_count_d;
      stuck_q     <= stuck_d;
      fault_q     <= fault_d;
      waiting_q   <= waiting_d;
      arrival_q   <= arrival_d;
    end
  end

  assign waiting_o      = waiting_q;
  assign arrival_o      = arrival_q;
  assign car_count_o    = car_count_q;
  assign sensor_fault_o = fault_q;

endmodule

// File: tb/tb_vlog_street_sensor.sv
// Scoreboard bench for vlog_street_sensor: stimulus queues cycle-tagged expectations, a
// monitor pops and compares them as the DUT outputs settle.
module tb_vlog_street_sensor;

  logic       clk_i;
  logic       rst_ni;
  logic       car_raw_i;
  logic       green_i;
  logic       waiting_o;
  logic       arrival_o;
  logic [3:0] car_count_o;
  logic       sensor_fault_o;

  vlog_street_sensor #(
    .DEBOUNCE      (3),
    .DEPART_CYCLES (2),
    .STUCK_LIMIT   (200)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .car_raw_i      (car_raw_i),
    .green_i        (green_i),
    .waiting_o      (waiting_o),
    .arrival_o      (arrival_o),
    .car_count_o    (car_count_o),
    .sensor_fault_o (sensor_fault_o)
  );

  typedef struct {
    int    cyc;
    int    cnt;
    bit    w;
    bit    a;
    bit    f;
    int    tot;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   arr_seen = 0;
  int   exp_tot  = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) if (arrival_o === 1'b1) arr_seen <= arr_seen + 1;

  task automatic check_field(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input exp_t e);
    int i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic exp_at(input int d, input int cnt, input bit w, input bit a, input bit f,
                        input string nm);
    exp_t e;
    e.cyc = cyc + d; e.cnt = cnt; e.w = w; e.a = a; e.f = f; e.tot = exp_tot; e.name = nm;
    push(e);
  endtask

  // Monitor: wakes after each falling clock edge and on reset assertion.
  initial begin
    forever begin
      @(negedge clk_i or negedge rst_ni);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s: sampled at cycle %0d expected at cycle %0d", mon_e.name, cyc,
                   mon_e.cyc);
        end else begin
          check_field({mon_e.name, "/count"},   32'(car_count_o),    32'(mon_e.cnt));
          check_field({mon_e.name, "/waiting"}, 32'(waiting_o),      32'(mon_e.w));
          check_field({mon_e.name, "/arrival"}, 32'(arrival_o),      32'(mon_e.a));
          check_field({mon_e.name, "/fault"},   32'(sensor_fault_o), 32'(mon_e.f));
          check_field({mon_e.name, "/arrivals"}, 32'(arr_seen),      32'(mon_e.tot));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Asserts reset between clock edges so only an asynchronous clear can satisfy the check.
  task automatic do_reset(input string nm);
    #2;
    exp_at(0, 0, 1'b0, 1'b0, 1'b0, nm);
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic arrive_pulse(input int hi, input int lo, input int cnt, input string nm);
    car_raw_i = 1'b1;
    exp_tot++;
    exp_at(5, cnt, 1'b1, 1'b1, 1'b0, nm);
    exp_at(6, cnt, 1'b1, 1'b0, 1'b0, {nm, "_after"});
    tick(hi);
    car_raw_i = 1'b0;
    tick(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni    = 1'b1;
    car_raw_i = 1'b0;
    green_i   = 1'b0;
    @(negedge clk_i);

    // 1: single clean acceptance
    do_reset("s1_reset");
    exp_at(1, 0, 1'b0, 1'b0, 1'b0, "s1_reset_state");
    tick(2);
    car_raw_i = 1'b1;
    exp_at(4, 0, 1'b0, 1'b0, 1'b0, "s1_pre_accept");
    exp_tot++;
    exp_at(5, 1, 1'b1, 1'b1, 1'b0, "s1_arrival");
    exp_at(6, 1, 1'b1, 1'b0, 1'b0, "s1_pulse_once");
    tick(20);
    car_raw_i = 1'b0;
    exp_at(10, 1, 1'b1, 1'b0, 1'b0, "s1_release");
    tick(12);

    // 2: glitches shorter than the debounce window
    do_reset("s2_reset");
    tick(2);
    for (int i = 0; i < 5; i++) begin
      car_raw_i = 1'b1;
      exp_at(5, 0, 1'b0, 1'b0, 1'b0, "s2_glitch");
      tick(2);
      car_raw_i = 1'b0;
      tick(4);
    end
    exp_at(3, 0, 1'b0, 1'b0, 1'b0, "s2_end");
    tick(6);

    // 3: three arrivals then drain under green
    do_reset("s3_reset");
    tick(2);
    for (int k = 1; k <= 3; k++) arrive_pulse(10, 10, k, "s3_arrive");
    green_i = 1'b1;
    exp_at(1, 3, 1'b1, 1'b0, 1'b0, "s3_g1");
    exp_at(2, 2, 1'b1, 1'b0, 1'b0, "s3_g2");
    exp_at(3, 2, 1'b1, 1'b0, 1'b0, "s3_g3");
    exp_at(4, 1, 1'b1, 1'b0, 1'b0, "s3_g4");
    exp_at(5, 1, 1'b1, 1'b0, 1'b0, "s3_g5");
    exp_at(6, 0, 1'b0, 1'b0, 1'b0, "s3_g6");
    exp_at(8, 0, 1'b0, 1'b0, 1'b0, "s3_empty");
    tick(8);
    green_i = 1'b0;
    tick(2);

    // 4: arrival coincides with departure, saturation, partial green discarded
    do_reset("s4_reset");
    tick(2);
    arrive_pulse(10, 10, 1, "s4_first");
    car_raw_i = 1'b1;
    tick(3);
    green_i = 1'b1;
    exp_at(1, 1, 1'b1, 1'b0, 1'b0, "s4_pre");
    exp_tot++;
    exp_at(2, 1, 1'b1, 1'b1, 1'b0, "s4_coincide");
    exp_at(3, 1, 1'b1, 1'b0, 1'b0, "s4_hold");
    exp_at(4, 0, 1'b0, 1'b0, 1'b0, "s4_drain");
    tick(4);
    green_i = 1'b0;
    tick(3);
    car_raw_i = 1'b0;
    tick(12);
    for (int k = 1; k <= 16; k++) arrive_pulse(4, 8, (k > 15) ? 15 : k, "s4_sat");
    green_i = 1'b1; tick(1);
    green_i = 1'b0; tick(1);
    green_i = 1'b1; tick(1);
    green_i = 1'b0;
    exp_at(1, 15, 1'b1, 1'b0, 1'b0, "s4_partial");
    tick(2);
    green_i = 1'b1;
    exp_at(1, 15, 1'b1, 1'b0, 1'b0, "s4_g1");
    exp_at(2, 14, 1'b1, 1'b0, 1'b0, "s4_depart");
    tick(2);
    green_i = 1'b0;
    tick(1);

    // 5: stuck sensor
    do_reset("s5_reset");
    tick(2);
    car_raw_i = 1'b1;
    exp_tot++;
    exp_at(5, 1, 1'b1, 1'b1, 1'b0, "s5_arrival");
    exp_at(204, 1, 1'b1, 1'b0, 1'b0, "s5_before_fault");
    exp_at(205, 1, 1'b1, 1'b0, 1'b1, "s5_fault");
    tick(250);
    car_raw_i = 1'b0;
    tick(10);
    green_i = 1'b1;
    exp_at(4, 0, 1'b1, 1'b0, 1'b1, "s5_forced_wait");
    tick(6);
    green_i = 1'b0;
    tick(1);
    do_reset("s5_fault_reset");
    exp_at(1, 0, 1'b0, 1'b0, 1'b0, "s5_after_reset");
    tick(2);

    // 6: reset mid-ARM with the vehicle still present, then at count 5
    car_raw_i = 1'b1;
    tick(3);
    do_reset("s6_reset_arm");
    exp_at(4, 0, 1'b0, 1'b0, 1'b0, "s6_no_early");
    exp_tot++;
    exp_at(5, 1, 1'b1, 1'b1, 1'b0, "s6_full_debounce");
    tick(8);
    car_raw_i = 1'b0;
    tick(10);
    for (int k = 2; k <= 5; k++) arrive_pulse(4, 8, k, "s6_build");
    do_reset("s6_reset_cnt5");
    tick(2);
    arrive_pulse(10, 10, 1, "s6_clean");

    tick(3);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never sampled, expected at cycle %0d", mon_e.name, mon_e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vlog_street_sensor.md
# vlog_street_sensor

Vehicle-presence front end for one street approach: synchronises and debounces a raw loop-sensor input, counts vehicles queued at red, and produces the `waiting` request consumed by the street controller FSM. The block feeds that FSM's `waiting` input (and, through the peer instance, `waiting_cross`). It takes back that FSM's `green` output to drain its queue count. A stuck-sensor monitor forces a fail-safe request and flags a fault.

## Interface
- `DEBOUNCE`, default 3: consecutive synchronised samples required to accept a sensor level change; legal 2..15.
- `DEPART_CYCLES`, default 2: green cycles per vehicle departure; legal 1..15.
- `STUCK_LIMIT`, default 200: consecutive cycles in PRES that declare a stuck sensor; legal 1..255.
- `clk`, input, 1: single clock; all state on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is taken synchronously by the system.
- `car_raw`, input, 1: raw, asynchronous, bouncy loop sensor (1 = metal present).
- `green`, input, 1: this approach's green from the street controller, same clock domain.
- `waiting`, output, 1: registered request to the controller.
- `arrival`, output, 1: one-cycle pulse per accepted vehicle.
- `car_count`, output, 4: vehicles queued, saturating 0..15.
- `sensor_fault`, output, 1: sticky stuck-sensor flag.

## Operation
- Synchroniser: two flops on `car_raw`; the second stage is `s`. No other logic reads `car_raw`.
- Debounce FSM, one-hot, 4 states:
  - IDLE: level 0.
  - ARM: rising candidate.
  - PRES: level 1.
  - REL: falling candidate.
  - The 4-bit `deb_cnt` holds the number of consecutive qualifying samples, including the current one.
- Debounce transitions:
  - IDLE: `s`=1 gives ARM with `deb_cnt`=1.
  - ARM: `s`=0 gives IDLE, with no arrival. `s`=1 increments `deb_cnt`; the edge on which the count would reach `DEBOUNCE` enters PRES and generates the arrival.
  - PRES: `s`=0 gives REL with `deb_cnt`=1.
  - REL: `s`=1 returns to PRES, with no new arrival. `s`=0 counts up; on reaching `DEBOUNCE` the FSM returns to IDLE.
  - Any non-one-hot state recovers to IDLE on the next edge.
- Queue counter `car_count`, updated on the same edge:
  - +1 on arrival.
  - −1 on departure.
  - Unchanged if both occur on the same edge.
  - Saturates at 15 on increment and at 0 on decrement.
- Departure timer (4-bit):
  - Counts cycles with `green`=1 and `car_count`≠0.
  - When it reaches `DEPART_CYCLES`, a departure is generated and the timer returns to 0 on the same edge.
  - Cleared whenever `green`=0 or `car_count`=0.
- Stuck monitor (8-bit):
  - Increments each cycle the FSM is in PRES.
  - Cleared on any cycle outside PRES; REL clears it.
  - Reaching `STUCK_LIMIT` sets `sensor_fault`, which holds until `rst`.
  - While `sensor_fault`=1, `waiting` is forced to 1. Counting continues normally.
- `waiting` register: next value is (next `car_count`≠0) OR (next `sensor_fault`).
- `arrival` register: set on the edge that enters PRES from ARM, otherwise 0.

## Timing
- Reset values: `waiting`=0, `arrival`=0, `car_count`=0, `sensor_fault`=0, FSM=IDLE, and all counters and synchroniser flops 0.
- Acceptance latency: let E0 be the first edge at which `car_raw`=1 meets setup and stays high. `arrival`, `car_count` increment and `waiting` all become visible after edge E(`DEBOUNCE`+1). Default: after E4.
- Release latency: `car_raw` falling at E0 gives IDLE after E(`DEBOUNCE`+1). Release does not change `car_count`.
- Glitch rejection: any high pulse shorter than `DEBOUNCE` synchronised samples produces no arrival.
- Departure: with `car_count`=N>0 and `green` held from edge G1, `car_count` decrements after G(`DEPART_CYCLES`), G(2·`DEPART_CYCLES`), and so on. `waiting` falls on the same edge on which `car_count` reaches 0.
- `green` dropping mid-interval discards the partial departure count.
- Fault: `sensor_fault` and forced `waiting` appear after the `STUCK_LIMIT`-th consecutive PRES cycle.
- Reset mid-operation: all outputs return to reset values asynchronously. No arrival may be reported for a vehicle already over the sensor until a full debounce completes after reset release.

## Test plan
1. Reset, then `car_raw` high from E0 and held → `arrival` pulses once after E4; `car_count`=1 and `waiting`=1 after E4; `sensor_fault` stays 0 if `car_raw` drops within 200 cycles.
2. `car_raw` high for 2 cycles then low, repeated 5 times → no `arrival`, `car_count`=0, `waiting`=0.
3. Three clean 10-cycle pulses separated by 10-cycle gaps → `car_count`=3. Then `green`=1 held → `car_count` 2, 1, 0 after G2, G4 and G6; `waiting` falls after G6.
4. Arrival edge coincides with a departure edge while `car_count`=1 → `car_count` stays 1, `waiting` stays 1. Also, 16 arrivals → `car_count` stays 15.
5. `car_raw` held high for 250 cycles → `sensor_fault`=1 after 200 PRES cycles. After `car_raw` drops and `car_count` drains to 0 under green, `waiting` remains 1; `rst` asserted → all outputs 0.
6. Assert `rst` mid-ARM and again at `car_count`=5 → outputs clear immediately; a subsequent clean pulse yields `car_count`=1.
